// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: steps the shared PC/IR/regfile/ALU/memory datapath
// through fetch, decode, execute, memory and writeback, stalling on mem_ready.
module mc_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_e state_q, state_d;
  logic   rdy;

  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = state_q;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        if (op == OP_RTYPE) begin
          if (funct == FN_ADDU || funct == FN_SUBU) state_d = EXEC_R;
          else if (funct == FN_JR)                  state_d = JUMP;
        end else if (op == OP_ORI || op == OP_LUI) begin
          state_d = EXEC_I;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = MEM_ADDR;
        end else if (op == OP_BEQ) begin
          state_d = BRANCH;
        end else if (op == OP_J || op == OP_JAL) begin
          state_d = JUMP;
        end
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = rdy ? WB_MEM : MEM_RD;
      MEM_WR:   state_d = rdy ? FETCH : MEM_WR;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Outputs decode the state register; the rst_n gate keeps every strobe low during reset.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    alu_ctrl   = 3'b000;
    pc_source  = 2'b00;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = rdy;
          ir_write  = rdy;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_ctrl  = (funct == FN_SUBU) ? 3'b001 : 3'b000;
        end
        WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = (op == OP_LUI) ? 3'b011 : 3'b010;
        end
        WB_I: reg_write = 1'b1;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = 3'b001;
          pc_source = 2'b01;
          pc_write  = zero;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = (op == OP_RTYPE) ? 2'b11 : 2'b10;
          if (op == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a per-instruction cycle model pushes expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_mc_control_fsm;
  localparam int W = 23;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mrd, mwr, iord, rw;
    logic [1:0] rdst, m2r;
    logic       asa;
    logic [1:0] asb;
    logic       ext;
    logic [2:0] alu;
    logic [1:0] pcs;
  } exp_t;

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LUI = 5;
  localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, ext_op;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  mc_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_ctrl(alu_ctrl), .pc_source(pc_source), .state(state)
  );

  assign dut_vec = {state, pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_ctrl, pc_source};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic int classify(input logic [5:0] iop, input logic [5:0] ifn);
    case (iop)
      6'h00: begin
        if (ifn == 6'h21) return K_ADDU;
        if (ifn == 6'h23) return K_SUBU;
        if (ifn == 6'h08) return K_JR;
        return K_NOP;
      end
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  task automatic check_now(input string name, input exp_t e);
    n_checks++;
    if (dut_vec === W'(e)) n_pass++;
    else $display("FAIL %s: got=%h required=%h (state got=%0d required=%0d)",
                  name, dut_vec, W'(e), state, e.st);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] ev;
      ev = exp_q.pop_front();
      n_checks++;
      if (dut_vec === ev) n_pass++;
      else $display("FAIL cycle t=%0t: got=%h required=%h (state got=%0d required=%0d)",
                    $time, dut_vec, ev, state, ev[W-1 -: 4]);
    end
  end

  task automatic cyc(input exp_t e, input logic [5:0] iop, input logic [5:0] ifn,
                     input logic rdy, input logic z);
    @(posedge clk);
    #1;
    op        = iop;
    funct     = ifn;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(W'(e));
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int wf,
                           input int wm, input logic bz, input bit abort);
    exp_t e;
    int   k;
    logic r;
    k = classify(iop, ifn);
    for (int w = 0; w <= wf; w++) begin
      r = (w == wf);
      e = mk(4'd0); e.mrd = 1'b1; e.asb = 2'b01; e.pcw = r; e.irw = r;
      cyc(e, 6'($urandom), 6'($urandom), r, rbit());
    end
    e = mk(4'd1); e.asb = 2'b11; e.ext = 1'b1;
    cyc(e, iop, ifn, rbit(), rbit());
    case (k)
      K_ADDU, K_SUBU: begin
        e = mk(4'd2); e.asa = 1'b1; e.alu = (k == K_SUBU) ? 3'd1 : 3'd0;
        cyc(e, iop, ifn, rbit(), rbit());
        e = mk(4'd7); e.rw = 1'b1; e.rdst = 2'b01;
        cyc(e, iop, ifn, rbit(), rbit());
      end
      K_ORI, K_LUI: begin
        e = mk(4'd3); e.asa = 1'b1; e.asb = 2'b10; e.alu = (k == K_LUI) ? 3'd3 : 3'd2;
        cyc(e, iop, ifn, rbit(), rbit());
        e = mk(4'd8); e.rw = 1'b1;
        cyc(e, iop, ifn, rbit(), rbit());
      end
      K_LW, K_SW: begin
        e = mk(4'd4); e.asa = 1'b1; e.asb = 2'b10; e.ext = 1'b1;
        cyc(e, iop, ifn, rbit(), rbit());
        for (int w = 0; w <= wm; w++) begin
          r = (w == wm);
          e = mk((k == K_LW) ? 4'd5 : 4'd6); e.iord = 1'b1;
          if (k == K_LW) e.mrd = 1'b1;
          else           e.mwr = 1'b1;
          cyc(e, iop, ifn, r, rbit());
          if (abort && !r) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_now("reset_abort_immediate", mk(4'd0));
            mem_ready = 1'b0;
            @(posedge clk);
            #1;
            check_now("reset_abort_held", mk(4'd0));
            rst_n = 1'b1;
            #1;
            e = mk(4'd0); e.mrd = 1'b1; e.asb = 2'b01;
            check_now("reset_release_fetch", e);
            return;
          end
        end
        if (k == K_LW) begin
          e = mk(4'd9); e.rw = 1'b1; e.m2r = 2'b01;
          cyc(e, iop, ifn, rbit(), rbit());
        end
      end
      K_BEQ: begin
        e = mk(4'd10); e.asa = 1'b1; e.alu = 3'd1; e.pcs = 2'b01; e.pcw = bz;
        cyc(e, iop, ifn, rbit(), bz);
      end
      K_J, K_JAL, K_JR: begin
        e = mk(4'd11); e.pcw = 1'b1; e.pcs = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin
          e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10;
        end
        cyc(e, iop, ifn, rbit(), rbit());
      end
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    logic [5:0] rop, rfn;
    int sel;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = 6'h23; funct = 6'h21;
    #3;
    check_now("reset_outputs_low", mk(4'd0));
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_held", mk(4'd0));
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    e = mk(4'd0); e.mrd = 1'b1; e.asb = 2'b01;
    check_now("first_fetch", e);

    run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
    run_instr(6'h23, 6'h15, 0, 2, 1'b0, 1'b0);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
    run_instr(6'h04, 6'h00, 1, 0, 1'b0, 1'b0);
    run_instr(6'h03, 6'h3f, 0, 0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h08, 0, 0, 1'b0, 1'b0);
    run_instr(6'h3f, 6'h21, 0, 0, 1'b0, 1'b0);
    run_instr(6'h2b, 6'h00, 0, 2, 1'b0, 1'b1);
    run_instr(6'h00, 6'h23, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 11);
      rfn = 6'($urandom);
      case (sel)
        0: begin rop = 6'h00; rfn = 6'h21; end
        1: begin rop = 6'h00; rfn = 6'h23; end
        2: begin rop = 6'h00; rfn = 6'h08; end
        3: rop = 6'h0d;
        4: rop = 6'h0f;
        5: rop = 6'h23;
        6: rop = 6'h2b;
        7: rop = 6'h04;
        8: rop = 6'h02;
        9: rop = 6'h03;
        10: begin
          rop = 6'($urandom);
          while (rop == 6'h00 || classify(rop, rfn) != K_NOP) rop = 6'($urandom);
        end
        default: begin
          rop = 6'h00;
          while (classify(rop, rfn) != K_NOP) rfn = 6'($urandom);
        end
      endcase
      run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2), rbit(), 1'b0);
    end

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got=%0d pending required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit. Sequences the shared datapath (PC, IR, regfile, single ALU, unified memory) over fetch, decode, execute, memory and writeback steps.
- Supports instructions addu, subu, jr, ori, lw, sw, beq, lui, j, jal.
- Outputs are Moore-decoded from the state register. Memory accesses stall on a ready handshake.

Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEM_RD/MEM_WR wait for mem_ready. 0: mem_ready is treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- reg_write  out  1  regfile write enable.
- reg_dst  out  2  write register select: 00=rt, 01=rd, 10=$31.
- mem_to_reg  out  2  write data select: 00=ALUOut, 01=MDR, 10=PC.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg.
- alu_src_b  out  2  ALU B select: 00=B reg, 01=4, 10=ext(imm), 11=sext(imm)<<2.
- ext_op  out  1  immediate extend: 1=sign, 0=zero.
- alu_ctrl  out  3  ALU op: 000 add, 001 sub, 010 or, 011 lui (B<<16).
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}, 11=A reg.
- state  out  4  current state, for debug.

Behaviour:
- State codes:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11.
  - Codes 12-15 are illegal and go to FETCH on the next edge with all outputs 0.
- Reset:
  - rst_n low → state=FETCH immediately, asynchronously.
  - While rst_n is low, every output is forced to 0. The reset mask is combinational.
  - The first FETCH is active on the first rising edge after rst_n deasserts.
  - Reset asserted mid-instruction aborts it. No write strobe may be high while rst_n is low.
- Defaults: any output not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=000, pc_source=00.
  - pc_write and ir_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Computes the branch target: alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctrl=000.
  - Next state by opcode:
    - op=0 with funct addu(100001) or subu(100011) → EXEC_R.
    - op=0 with funct jr(001000) → JUMP.
    - ori(001101) or lui(001111) → EXEC_I.
    - lw(100011) or sw(101011) → MEM_ADDR.
    - beq(000100) → BRANCH.
    - j(000010) or jal(000011) → JUMP.
    - Any other op/funct → FETCH with no write; the instruction is treated as a NOP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl=000 for addu or 001 for subu → WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctrl=010 for ori or 011 for lui → WB_I.
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctrl=000 → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then → WB_MEM.
- WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01 → FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1. Holds until mem_ready=1, then → FETCH.
  - mem_write stays high for every wait cycle.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_ctrl=001, pc_source=01.
  - pc_write=zero. Always → FETCH.
- JUMP:
  - pc_write=1.
  - pc_source=11 when op=0 (jr), else 10.
  - For jal: reg_write=1, reg_dst=10, mem_to_reg=10. This writes PC, which already holds PC+4 after FETCH.
  - Always → FETCH.
- Timing:
  - op, funct and zero are sampled only in the states named above.
  - IR is stable after FETCH, so decode is taken from the IR contents.
- Cycle counts with zero wait states:
  - R, I: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each mem_ready=0 cycle adds 1 cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
- Reset, then op=0, funct=100001, mem_ready=1 → states 0,1,2,7,0. reg_write=1 only in WB_R with reg_dst=01. pc_write=1 only in FETCH.
- lw (op=100011) with mem_ready=0 for 2 cycles in MEM_RD → states 0,1,4,5,5,5,9,0. mem_read and i_or_d high across all 3 MEM_RD cycles.
- beq (op=000100): with zero=1, pc_write=1 in BRANCH with pc_source=01. With zero=0, pc_write=0. Both take 3 cycles.
- jal (op=000011) → JUMP asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. jr (op=0, funct=001000) → pc_source=11, reg_write=0.
- Illegal op=111111 → DECODE returns to FETCH. No reg_write or mem_write at any point.
- sw in MEM_WR with mem_ready=0, then rst_n driven low mid-cycle → state=0 and mem_write=0 immediately. After release, FETCH restarts with mem_read=1.
